if_id_branch_ctrl: RTL and testbench

- Consumer end of the fetch interface: latches the fetched PC+4 and instruction into the IF/ID pipeline register.
- Resolves beq/bne in ID and returns the branch select and branch target to the fetch stage's PC source mux.
- Detects load-use and branch-operand hazards, then stalls fetch or squashes the wrong-path instruction.
- Sits between the fetch stage and the ID/EX register; reads the register file through rs/rt address outputs.

---
 rtl/if_id_branch_ctrl.sv | 121 ++++++++++++
 tb/tb_if_id_branch_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_branch_ctrl.sv
// IF/ID pipeline register with ID-stage branch resolution and hazard control.
// Latches PC+4 and the fetched instruction, resolves beq/bne in ID and drives
// the fetch PC source mux.
// The register stalls on load-use and on branch-operand hazards.
// When taken, the branch squashes the wrong-path fetch.
// Optional feature: define ID_JUMP_EN to resolve j (opcode 6'b000010) in ID
// as an always-taken jump.
module if_id_branch_ctrl #(
  parameter logic [5:0]  OP_BEQ   = 6'b000100,
  parameter logic [5:0]  OP_BNE   = 6'b000101,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc4_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_wreg,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_wreg,
  output logic [31:0] pc4_id,
  output logic [31:0] instr_id,
  output logic        valid_id,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        pc_write,
  output logic        id_bubble
);

  logic [5:0]  opcode;
  logic        is_beq;
  logic        is_br;
  logic        ex_hit;
  logic        mem_hit;
  logic        load_use;
  logic        br_dep;
  logic        stall;
  logic        br_taken;
  logic        taken;
  logic [31:0] br_offset;
  logic [31:0] br_target;

  assign opcode  = instr_id[31:26];
  assign rs_addr = instr_id[25:21];
  assign rt_addr = instr_id[20:16];

  assign is_beq = valid_id & (opcode == OP_BEQ);
  assign is_br  = valid_id & ((opcode == OP_BEQ) | (opcode == OP_BNE));

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  assign ex_hit  = (ex_wreg != 5'd0) & ((ex_wreg == rs_addr) | (ex_wreg == rt_addr));
  assign mem_hit = (mem_wreg != 5'd0) & ((mem_wreg == rs_addr) | (mem_wreg == rt_addr));

  assign load_use = valid_id & ex_mem_read & ex_hit;
  assign br_dep   = is_br & ((ex_reg_write & ex_hit) | (mem_mem_read & mem_hit));
  assign stall    = load_use | br_dep;

  assign br_offset = {{14{instr_id[15]}}, instr_id[15:0], 2'b00};
  assign br_target = pc4_id + br_offset;

  // Branch comparison: equality for beq, inequality for bne, suppressed while stalled.
  always_comb begin
    // NOTE: default first so every path assigns br_taken and no latch is inferred.
    br_taken = 1'b0;
    if (is_br && !stall) begin
      if (is_beq) br_taken = (rs_data == rt_data);
      else        br_taken = (rs_data != rt_data);
    end
  end

`ifdef ID_JUMP_EN
  localparam logic [5:0] OP_J = 6'b000010;

  logic        is_j;
  logic        j_taken;
  logic [31:0] j_target;

  // A jump has no register operands of its own; only a load-use stall holds it.
  assign is_j     = valid_id & (opcode == OP_J);
  assign j_taken  = is_j & ~stall;
  assign j_target = {pc4_id[31:28], instr_id[25:0], 2'b00};

  assign taken         = br_taken | j_taken;
  assign branch_target = is_j ? j_target : br_target;
`else
  assign taken         = br_taken;
  assign branch_target = br_target;
`endif

  assign pcsrc     = taken;
  assign pc_write  = ~stall;
  assign id_bubble = stall;

  // IF/ID register: reset, hold on stall, squash after a taken redirect, else load.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      pc4_id   <= 32'd0;
      instr_id <= NOP_WORD;
      valid_id <= 1'b0;
    end else if (stall) begin
      pc4_id   <= pc4_id;
      instr_id <= instr_id;
      valid_id <= valid_id;
    end else if (taken) begin
      pc4_id   <= pc4_in;
      instr_id <= NOP_WORD;
      valid_id <= 1'b0;
    end else begin
      pc4_id   <= pc4_in;
      instr_id <= instr_in;
      valid_id <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_branch_ctrl.sv
// Directed bench for if_id_branch_ctrl: reset, beq/bne resolution, load-use
// and branch-on-load stalls, the register-0 rule, jump handling and reset
// during a stall.
module tb_if_id_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc4_in;
  logic [31:0] instr_in;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [4:0]  ex_wreg;
  logic        mem_mem_read;
  logic [4:0]  mem_wreg;
  logic [31:0] pc4_id;
  logic [31:0] instr_id;
  logic        valid_id;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic        pc_write;
  logic        id_bubble;

  int vectors = 0;
  int miscompares = 0;

  if_id_branch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pc4_in        (pc4_in),
    .instr_in      (instr_in),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_wreg       (ex_wreg),
    .mem_mem_read  (mem_mem_read),
    .mem_wreg      (mem_wreg),
    .pc4_id        (pc4_id),
    .instr_id      (instr_id),
    .valid_id      (valid_id),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .pc_write      (pc_write),
    .id_bubble     (id_bubble)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pc4_in = '0; instr_in = '0; rs_data = '0; rt_data = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_wreg = '0;
    mem_mem_read = 1'b0; mem_wreg = '0;

    // Reset held for two cycles
    tick(); tick();
    check("rst_pc4_id", pc4_id, 32'h0);
    check("rst_instr_id", instr_id, 32'h0);
    check("rst_valid_id", {31'd0, valid_id}, 32'd0);
    check("rst_pcsrc", {31'd0, pcsrc}, 32'd0);
    check("rst_pc_write", {31'd0, pc_write}, 32'd1);
    check("rst_id_bubble", {31'd0, id_bubble}, 32'd0);
    check("rst_branch_target", branch_target, 32'h0);

    // First instruction after release: add $3,$1,$2
    rst = 1'b0; pc4_in = 32'h4; instr_in = 32'h00221820;
    tick();
    check("first_instr_id", instr_id, 32'h00221820);
    check("first_valid_id", {31'd0, valid_id}, 32'd1);
    check("first_pc4_id", pc4_id, 32'h4);
    check("first_rs_addr", {27'd0, rs_addr}, 32'd1);
    check("first_rt_addr", {27'd0, rt_addr}, 32'd2);
    check("first_pcsrc", {31'd0, pcsrc}, 32'd0);

    // Taken beq $1,$2,+3 at pc4 0x10 -> target 0x1C
    pc4_in = 32'h10; instr_in = 32'h10220003;
    tick();
    rs_data = 32'd5; rt_data = 32'd5;
    pc4_in = 32'h14; instr_in = 32'h11111111;
    #1;
    check("beq_pcsrc", {31'd0, pcsrc}, 32'd1);
    check("beq_target", branch_target, 32'h1C);
    check("beq_pc_write", {31'd0, pc_write}, 32'd1);
    tick();
    check("beq_flush_instr", instr_id, 32'h0);
    check("beq_flush_valid", {31'd0, valid_id}, 32'd0);
    check("beq_flush_pc4", pc4_id, 32'h14);
    check("beq_flush_pcsrc", {31'd0, pcsrc}, 32'd0);

    // Not-taken bne $1,$2,+3 with equal operands
    pc4_in = 32'h20; instr_in = 32'h14220003;
    tick();
    rs_data = 32'd7; rt_data = 32'd7;
    pc4_in = 32'h24; instr_in = 32'h00832020;
    #1;
    check("bne_pcsrc", {31'd0, pcsrc}, 32'd0);
    check("bne_target", branch_target, 32'h2C);
    tick();
    check("bne_next_instr", instr_id, 32'h00832020);
    check("bne_next_valid", {31'd0, valid_id}, 32'd1);

    // Load-use on $4 (ID holds add $4,$4,$3)
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_wreg = 5'd4;
    pc4_in = 32'h28; instr_in = 32'h22222222;
    #1;
    check("lu_pc_write", {31'd0, pc_write}, 32'd0);
    check("lu_id_bubble", {31'd0, id_bubble}, 32'd1);
    tick();
    check("lu_hold_instr", instr_id, 32'h00832020);
    check("lu_hold_pc4", pc4_id, 32'h24);
    check("lu_hold_valid", {31'd0, valid_id}, 32'd1);
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_wreg = 5'd0;
    mem_mem_read = 1'b1; mem_wreg = 5'd4;
    instr_in = 32'h00001020;
    #1;
    check("lu_clear_pc_write", {31'd0, pc_write}, 32'd1);
    check("lu_clear_bubble", {31'd0, id_bubble}, 32'd0);
    tick();
    mem_mem_read = 1'b0; mem_wreg = 5'd0;
    check("r0_instr", instr_id, 32'h00001020);

    // Load to $0 never matches an instruction reading $0
    ex_mem_read = 1'b1; ex_wreg = 5'd0;
    #1;
    check("r0_pc_write", {31'd0, pc_write}, 32'd1);
    check("r0_bubble", {31'd0, id_bubble}, 32'd0);
    ex_mem_read = 1'b0;

    // Branch on load: beq $3,$0,-2 at pc4 0x40 -> target 0x38
    pc4_in = 32'h40; instr_in = 32'h1060FFFE;
    tick();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_wreg = 5'd3;
    rs_data = 32'd9; rt_data = 32'd9;
    pc4_in = 32'h44; instr_in = 32'h33333333;
    #1;
    check("bl1_pc_write", {31'd0, pc_write}, 32'd0);
    check("bl1_bubble", {31'd0, id_bubble}, 32'd1);
    check("bl1_pcsrc", {31'd0, pcsrc}, 32'd0);
    tick();
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_wreg = 5'd0;
    mem_mem_read = 1'b1; mem_wreg = 5'd3;
    #1;
    check("bl2_pc_write", {31'd0, pc_write}, 32'd0);
    check("bl2_pcsrc", {31'd0, pcsrc}, 32'd0);
    check("bl2_hold_instr", instr_id, 32'h1060FFFE);
    tick();
    mem_mem_read = 1'b0; mem_wreg = 5'd0;
    #1;
    check("bl3_pc_write", {31'd0, pc_write}, 32'd1);
    check("bl3_pcsrc", {31'd0, pcsrc}, 32'd1);
    check("bl3_target", branch_target, 32'h38);
    tick();
    check("bl_flush_instr", instr_id, 32'h0);
    check("bl_flush_valid", {31'd0, valid_id}, 32'd0);
    check("bl_flush_pc4", pc4_id, 32'h44);

    // Jump j 0x000040 at pc4 0x30000004
    pc4_in = 32'h30000004; instr_in = 32'h08000040;
    tick();
    pc4_in = 32'h30000008; instr_in = 32'h44444444;
    #1;
`ifdef ID_JUMP_EN
    check("j_pcsrc", {31'd0, pcsrc}, 32'd1);
    check("j_target", branch_target, 32'h30000100);
    tick();
    check("j_flush_instr", instr_id, 32'h0);
    check("j_flush_valid", {31'd0, valid_id}, 32'd0);
`else
    check("j_pcsrc", {31'd0, pcsrc}, 32'd0);
    tick();
    check("j_pass_instr", instr_id, 32'h44444444);
    check("j_pass_valid", {31'd0, valid_id}, 32'd1);
`endif

    // Reset during a load-use stall: add $6,$5,$0 with load to $5 in EX
    pc4_in = 32'h50; instr_in = 32'h00A03020;
    tick();
    ex_mem_read = 1'b1; ex_wreg = 5'd5;
    #1;
    check("rs_stall_pre", {31'd0, pc_write}, 32'd0);
    rst = 1'b1;
    tick();
    check("rs_stall_instr", instr_id, 32'h0);
    check("rs_stall_valid", {31'd0, valid_id}, 32'd0);
    check("rs_stall_pc4", pc4_id, 32'h0);
    check("rs_stall_pc_write", {31'd0, pc_write}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
